// File: rtl/conv_enc_pkg.sv
// Shared constants, enums and the rate-1/2 K=7 encoder kernel for the
// 802.11a convolutional encoder.
package conv_enc_pkg;

  localparam int unsigned K        = 7;
  localparam int unsigned SR_W     = K - 1;
  localparam int unsigned TAIL_LEN = 6;
  localparam int unsigned TAIL_W   = 3;

  localparam logic [K-1:0] G0 = 7'o133;
  localparam logic [K-1:0] G1 = 7'o171;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'b00,
    RATE_2_3  = 2'b01,
    RATE_3_4  = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    TAIL = 2'b10,
    DONE = 2'b11
  } state_e;

  // Register holds {d1..d6} with d1 at the MSB, so {d0, sr} lines up with the
  // generator polynomials written MSB-first.
  function automatic logic [1:0] encode_pair(input logic d0, input logic [SR_W-1:0] sr);
    logic [K-1:0] vec;
    vec = {d0, sr};
    return {^(vec & G0), ^(vec & G1)};
  endfunction

endpackage

// File: rtl/conv_encoder_punct_puncture_ctrl.sv
// Puncture phase counter and keep-mask generator for rates 1/2, 2/3 and 3/4.
module puncture_ctrl
  import conv_enc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  input  rate_e      rate,
  output logic [1:0] mask
);

  logic [1:0] phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= 2'b00;
    end else if (clear) begin
      phase <= 2'b00;
    end else if (advance) begin
      case (rate)
        RATE_2_3: phase <= (phase == 2'd1) ? 2'd0 : 2'd1;
        RATE_3_4: phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        default:  phase <= 2'd0;
      endcase
    end
  end

  always_comb begin
    mask = 2'b11;
    case (rate)
      RATE_2_3: if (phase == 2'd1) mask = 2'b10;
      RATE_3_4: begin
        if (phase == 2'd1) mask = 2'b10;
        else if (phase == 2'd2) mask = 2'b01;
      end
      default: mask = 2'b11;
    endcase
  end

endmodule

// File: rtl/conv_encoder_punct.sv
// 802.11a K=7 convolutional encoder with puncturing and automatic zero-tail
// termination; one registered coded pair per encoded data or tail bit.
module conv_encoder_punct
  import conv_enc_pkg::*;
#(
  parameter int unsigned N     = 96,
  parameter int unsigned CNT_W = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] rate,
  input  logic       enable,
  input  logic       Ein,
  output logic       ready,
  output logic [1:0] Eout,
  output logic [1:0] outMask,
  output logic       outputValid,
  output logic       done
);

  state_e            state, state_d;
  logic [SR_W-1:0]   sr, sr_d;
  logic [CNT_W-1:0]  bit_cnt, cnt_d;
  logic [TAIL_W-1:0] tail_cnt, tail_d;
  rate_e             rate_q, rate_d;

  logic [1:0] eout_d, mask_d, code, punct_mask;
  logic       valid_d, done_d, ready_d;
  logic       encode, d0, clear;

  puncture_ctrl u_punct (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (encode),
    .rate    (rate_q),
    .mask    (punct_mask)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      tail_cnt    <= '0;
      rate_q      <= RATE_1_2;
      Eout        <= 2'b00;
      outMask     <= 2'b00;
      outputValid <= 1'b0;
      done        <= 1'b0;
      ready       <= 1'b0;
    end else begin
      state       <= state_d;
      sr          <= sr_d;
      bit_cnt     <= cnt_d;
      tail_cnt    <= tail_d;
      rate_q      <= rate_d;
      Eout        <= eout_d;
      outMask     <= mask_d;
      outputValid <= valid_d;
      done        <= done_d;
      ready       <= ready_d;
    end
  end

  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = bit_cnt;
    tail_d  = tail_cnt;
    rate_d  = rate_q;
    encode  = 1'b0;
    d0      = 1'b0;
    clear   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          sr_d    = '0;
          cnt_d   = '0;
          tail_d  = '0;
          rate_d  = (rate == 2'(RATE_RSVD)) ? RATE_1_2 : rate_e'(rate);
          state_d = DATA;
        end
      end
      DATA: begin
        if (enable) begin
          encode = 1'b1;
          d0     = Ein;
          cnt_d  = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(N - 1)) begin
            tail_d  = '0;
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        encode = 1'b1;
        tail_d = tail_cnt + TAIL_W'(1);
        if (tail_cnt == TAIL_W'(TAIL_LEN - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    code = encode_pair(d0, sr);
    if (encode) sr_d = {d0, sr[SR_W-1:1]};

    // Idle cycles present an all-zero pair and mask.
    valid_d = encode;
    mask_d  = encode ? punct_mask : 2'b00;
    eout_d  = code & mask_d;
    done_d  = (state_d == DONE);
    ready_d = (state_d == DATA);
  end

endmodule
